mult_iter_cell: RTL and testbench
=================================

Name: mult_iter_cell

Overview:
Parametrised iterative multiplier cell for the Nios II-class datapath. Successor to the fixed 32x4 partial-product cell.
- Consumes DIGIT_W bits of src2 per cycle; accumulates the full 2*WIDTH product.
- Returns the low word (MUL) or the high word (MULXUU/MULXSU/MULXSS).
- Uses a ready/start/valid handshake and supports abort, for use in the A-stage multi-cycle ALU path.

Parameters:
WIDTH, 32, operand and result width
DIGIT_W, 4, src2 bits retired per cycle; must divide WIDTH exactly, otherwise elaboration error
N_DIGITS, WIDTH/DIGIT_W, derived localparam; number of RUN cycles (8 at default)

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  request; accepted only on an edge where in_ready=1
mode  in  2  00 MUL low word; 01 MULXUU high u*u; 10 MULXSU high s(src1)*u(src2); 11 MULXSS high s*s
src1  in  WIDTH  multiplicand
src2  in  WIDTH  multiplier
abort  in  1  cancel the operation in flight
in_ready  out  1  cell idle, can accept start
busy  out  1  operation in flight (RUN or FIX)
out_valid  out  1  one-cycle pulse: result is new
result  out  WIDTH  selected product word; held until the next completion

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE
  - in_ready=1, busy=0, out_valid=0, result=0
  - accumulator and operand registers cleared
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1 (accept edge E0):
  - Latch mode and sign flags.
  - Latch |src1| and |src2| as WIDTH-bit unsigned magnitudes. A signed operand is treated as negative if its MSB=1 and its mode treats it as signed. The minimum negative value's magnitude 2^(WIDTH-1) fits.
  - Latch neg = sign1 XOR sign2.
  - Clear the 2*WIDTH accumulator, clear the digit counter, go to RUN.
- RUN, each edge:
  - acc += (mag1 * mag2[DIGIT_W-1:0]) << (cnt*DIGIT_W)
  - mag2 >>= DIGIT_W; cnt++
  - After the N_DIGITS-th digit, go to FIX.
- FIX edge:
  - p = neg ? -acc : acc (2*WIDTH two's complement).
  - result = mode==00 ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH].
  - out_valid=1 for this cycle only; go to IDLE.
- Latency: accept at edge E0, result registered at edge E(N_DIGITS+1). That is 9 edges at default. Throughput: one operation per N_DIGITS+2 cycles.
- in_ready = (state==IDLE); busy = !in_ready. in_ready rises in the same cycle out_valid is high, so the next start can be accepted on the following edge.
- start while busy: ignored, with no effect on the operation in flight.
- abort=1 in RUN or FIX: next edge goes to IDLE, out_valid stays 0, result unchanged. abort has priority over completion in the same cycle. abort in IDLE is ignored; abort and start together in IDLE means start is ignored.
- Low-word results are sign-independent. The MUL low word equals the MULXUU low word for identical operands.
- All arithmetic is modulo 2^(2*WIDTH) with no overflow flag.

Optional Feature:
MULT_ITER_CELL_EARLY_EXIT_EN
- Defined: in RUN, if the remaining shifted mag2 (after the current digit) is 0, go to FIX on that edge.
  - Latency becomes (number of significant digits of |src2|, minimum 1) + 1.
  - src2=0 gives out_valid at edge E2.
- Undefined: fixed latency of N_DIGITS+1 edges regardless of data.

Decomposition:
- Package mult_iter_cell_pkg contains:
  - mode encoding constants MODE_MUL, MODE_MULXUU, MODE_MULXSU, MODE_MULXSS
  - FSM state type (IDLE/RUN/FIX)
  - helper function for magnitude/sign extraction
- One sub-module: mult_iter_digit_pe, a combinational WIDTH x DIGIT_W partial product shifted and added into the 2*WIDTH accumulator. The top module keeps the FSM, registers and sign fix-up.

Test Plan:
1. MUL, src1=0x0000_1234, src2=0x0000_0010 -> result=0x0001_2340; out_valid exactly 9 edges after accept, single-cycle pulse.
2. src1=0xFFFF_FFFF, src2=0x0000_0002 -> MULXSS result=0xFFFF_FFFF; MULXUU result=0x0000_0001; MUL result=0xFFFF_FFFE.
3. MULXSS 0x8000_0000*0x8000_0000 -> 0x4000_0000; MULXSU 0x8000_0000*0xFFFF_FFFF -> 0x8000_0000.
4. Abort asserted on the 4th RUN cycle -> no out_valid, result keeps its prior value, in_ready=1 next cycle. A following MUL 7*6 returns 0x0000_002A.
5. reset_n pulled low mid-RUN, asynchronously between edges -> in_ready=1, busy=0, out_valid=0, result=0 before the next edge. Start is ignored while busy; a back-to-back start on the out_valid cycle's next edge is accepted.
6. With MULT_ITER_CELL_EARLY_EXIT_EN: MUL 0x1234*0x0000_0003 -> out_valid at edge E2; src2=0xF000_0000 -> edge E9.

Source files
------------

// File: rtl/mult_iter_cell_pkg.sv
// Shared encodings for the iterative multiplier cell: product-select modes,
// FSM states and the operand sign helper.
package mult_iter_cell_pkg;

    localparam logic [1:0] MODE_MUL    = 2'b00;
    localparam logic [1:0] MODE_MULXUU = 2'b01;
    localparam logic [1:0] MODE_MULXSU = 2'b10;
    localparam logic [1:0] MODE_MULXSS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // An operand is negative only when its MSB is set and the mode reads it as signed.
    function automatic logic operand_is_neg(input logic [1:0] mode, input logic msb,
                                            input logic is_src1);
        logic signed_s;
        if (is_src1) begin
            signed_s = (mode == MODE_MULXSU) || (mode == MODE_MULXSS);
        end else begin
            signed_s = (mode == MODE_MULXSS);
        end
        return signed_s & msb;
    endfunction

endpackage

// File: rtl/mult_iter_cell_if.sv
// Request/response bundle between the A-stage ALU sequencer and the
// iterative multiplier cell.
interface mult_iter_cell_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             abort;
    logic             in_ready;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] result;

    modport master (
        output start, mode, src1, src2, abort,
        input  in_ready, busy, out_valid, result
    );

    modport slave (
        input  start, mode, src1, src2, abort,
        output in_ready, busy, out_valid, result
    );
endinterface

// File: rtl/mult_iter_digit_pe.sv
// Combinational digit step: mag1 times one DIGIT_W-bit digit of mag2,
// shifted to the digit position and added into the double-width accumulator.
module mult_iter_digit_pe #(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 4,
    parameter int CNT_W   = 4
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mag1,
    input  logic [DIGIT_W-1:0] digit,
    input  logic [CNT_W-1:0]   cnt,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [2*WIDTH-1:0] pp_s;
    logic [31:0]        shamt_s;

    assign pp_s     = (2*WIDTH)'(mag1) * (2*WIDTH)'(digit);
    assign shamt_s  = 32'(cnt) * 32'(DIGIT_W);
    assign acc_next = acc + (pp_s << shamt_s);
endmodule

// File: rtl/mult_iter_cell.sv
// Iterative sign-magnitude multiplier retiring DIGIT_W bits of src2 per cycle.
// Optional MULT_ITER_CELL_EARLY_EXIT_EN: leave RUN once the remaining src2 digits are all zero.
module mult_iter_cell
    import mult_iter_cell_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    mult_iter_cell_if.slave    bus
);
    localparam int N_DIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W    = $clog2(N_DIGITS + 1);

    if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit_w
        $error("mult_iter_cell: DIGIT_W must divide WIDTH exactly");
    end

    state_t             state_r, state_nx_s;
    logic [1:0]         mode_r;
    logic               neg_r;
    logic [WIDTH-1:0]   mag1_r, mag2_r;
    logic [2*WIDTH-1:0] acc_r, acc_nx_s, prod_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   result_r, word_s;
    logic               out_valid_r;
    logic               accept_s, last_digit_s, neg1_s, neg2_s;

    assign accept_s = (state_r == ST_IDLE) && bus.start && !bus.abort;
    assign neg1_s   = operand_is_neg(bus.mode, bus.src1[WIDTH-1], 1'b1);
    assign neg2_s   = operand_is_neg(bus.mode, bus.src2[WIDTH-1], 1'b0);

`ifdef MULT_ITER_CELL_EARLY_EXIT_EN
    assign last_digit_s = (cnt_r == CNT_W'(N_DIGITS - 1)) || ((mag2_r >> DIGIT_W) == '0);
`else
    assign last_digit_s = (cnt_r == CNT_W'(N_DIGITS - 1));
`endif

    mult_iter_digit_pe #(
        .WIDTH   (WIDTH),
        .DIGIT_W (DIGIT_W),
        .CNT_W   (CNT_W)
    ) u_pe (
        .acc      (acc_r),
        .mag1     (mag1_r),
        .digit    (mag2_r[DIGIT_W-1:0]),
        .cnt      (cnt_r),
        .acc_next (acc_nx_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; abort wins over completion
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nx_s = ST_RUN;
                else          state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.abort)         state_nx_s = ST_IDLE;
                else if (last_digit_s) state_nx_s = ST_FIX;
                else                   state_nx_s = ST_RUN;
            end
            ST_FIX:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Sign fix-up of the unsigned magnitude product and word select
    always_comb begin
        prod_s = acc_r;
        word_s = '0;
        if (neg_r) prod_s = -acc_r;
        else       prod_s = acc_r;
        if (mode_r == MODE_MUL) word_s = prod_s[WIDTH-1:0];
        else                    word_s = prod_s[2*WIDTH-1:WIDTH];
    end

    // Operand capture, digit accumulation and result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r      <= MODE_MUL;
            neg_r       <= 1'b0;
            mag1_r      <= '0;
            mag2_r      <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            result_r    <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mode_r <= bus.mode;
                        neg_r  <= neg1_s ^ neg2_s;
                        mag1_r <= neg1_s ? -bus.src1 : bus.src1;
                        mag2_r <= neg2_s ? -bus.src2 : bus.src2;
                        acc_r  <= '0;
                        cnt_r  <= '0;
                    end
                end
                ST_RUN: begin
                    if (!bus.abort) begin
                        acc_r  <= acc_nx_s;
                        mag2_r <= mag2_r >> DIGIT_W;
                        cnt_r  <= cnt_r + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (!bus.abort) begin
                        result_r    <= word_s;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
endmodule

// File: tb/tb_mult_iter_cell.sv
// Scoreboard bench for mult_iter_cell: directed vectors push expected words
// and completion cycles; a negedge monitor pops and compares on out_valid.
module tb_mult_iter_cell;
    import mult_iter_cell_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mult_iter_cell_if #(.WIDTH(32)) bus();

    mult_iter_cell #(.WIDTH(32), .DIGIT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // monitor: compare every completion against the scoreboard head
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            check("pulse_width", {63'd0, prev_valid}, 64'd0);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got result %0h with nothing outstanding", bus.result);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", {32'd0, bus.result}, {32'd0, mon_e.res});
                check("latency", 64'(cyc), 64'(mon_e.due));
            end
        end
        prev_valid = bus.out_valid;
    end

    // Drive one request once the cell is ready; returns the accept edge index.
    task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int lat_ee, input bit push,
                         output int acc_cyc);
        int lat;
        int waited;
        exp_t e;
`ifdef MULT_ITER_CELL_EARLY_EXIT_EN
        lat = lat_ee;
`else
        lat = 9;
`endif
        waited = 0;
        acc_cyc = 0;
        while (bus.in_ready !== 1'b1) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL in_ready_timeout: got busy after %0d cycles, expected idle", waited);
                return;
            end
        end
        bus.mode  = m;
        bus.src1  = a;
        bus.src2  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        acc_cyc = cyc;
        if (push) begin
            e.res = expv;
            e.due = acc_cyc + lat;
            sb_q.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int a_cyc, b_cyc, w;
        bus.start = 1'b0;
        bus.mode  = MODE_MUL;
        bus.src1  = 32'd0;
        bus.src2  = 32'd0;
        bus.abort = 1'b0;

        #12;
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("rst_busy",      {63'd0, bus.busy},      64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_result",    {32'd0, bus.result},    64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        issue(MODE_MUL,    32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 3, 1'b1, a_cyc);
        issue(MODE_MULXSS, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2, 1'b1, a_cyc);
        issue(MODE_MULXUU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 2, 1'b1, a_cyc);
        issue(MODE_MUL,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 2, 1'b1, a_cyc);
        issue(MODE_MULXSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2, 1'b1, a_cyc);
        issue(MODE_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, 1'b1, a_cyc);
        issue(MODE_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b1, a_cyc);
        issue(MODE_MUL,    32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 9, 1'b1, a_cyc);
        issue(MODE_MULXSS, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 1'b1, a_cyc);
        issue(MODE_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9, 1'b1, a_cyc);
        issue(MODE_MULXSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 9, 1'b1, a_cyc);

        // abort during the 4th RUN cycle
        issue(MODE_MUL, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0, 9, 1'b0, a_cyc);
        repeat (3) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        check("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("abort_busy",     {63'd0, bus.busy},     64'd0);
        check("abort_valid",    {63'd0, bus.out_valid}, 64'd0);
        check("abort_result",   {32'd0, bus.result},   64'h8000_0000);
        issue(MODE_MUL, 32'd7, 32'd6, 32'h0000_002A, 2, 1'b1, a_cyc);

        // start while busy is ignored; next request lands on the edge after out_valid
        issue(MODE_MUL, 32'd5, 32'h1000_0003, 32'h5000_000F, 9, 1'b1, a_cyc);
        @(negedge clk);
        bus.mode  = MODE_MULXUU;
        bus.src1  = 32'd9;
        bus.src2  = 32'd9;
        bus.start = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        issue(MODE_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, 1'b1, b_cyc);
        check("back_to_back_accept", 64'(b_cyc), 64'(a_cyc + 9 + 1));

        // asynchronous reset between edges while running
        issue(MODE_MUL, 32'd5, 32'hFFFF_FFFF, 32'h0, 9, 1'b0, a_cyc);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("arst_busy",      {63'd0, bus.busy},      64'd0);
        check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("arst_result",    {32'd0, bus.result},    64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        issue(MODE_MUL, 32'h0000_1234, 32'h0000_0003, 32'h0000_369C, 2, 1'b1, a_cyc);
        issue(MODE_MUL, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 2, 1'b1, a_cyc);
        issue(MODE_MUL, 32'h0000_0001, 32'hF000_0000, 32'hF000_0000, 9, 1'b1, a_cyc);

        w = 0;
        while (sb_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("drain_outstanding", 64'(sb_q.size()), 64'd0);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
